// File: rtl/irq_entry_ctrl.sv
// rtl/irq_entry_ctrl.sv - IRQ entry/return sequencer: LR/SPSR save, CPSR update, PC vectoring and exception return
module irq_entry_ctrl (
    input  logic        clk,
    input  logic        clr,
    input  logic        INT_irq,
    input  logic        instr_done,
    input  logic        irq_ret,
    input  logic [31:0] cpsr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] lr_in,
    output logic        INTA_irq,
    output logic [1:0]  PC_s,
    output logic        Write_PC,
    output logic [31:0] pc_wdata,
    output logic        lr_we,
    output logic [31:0] lr_wdata,
    output logic        cpsr_we,
    output logic [31:0] cpsr_wdata,
    output logic        stall,
    output logic        in_irq
);

    localparam logic [31:0] VECTOR   = 32'h0000_0018;
    localparam logic [4:0]  IRQ_MODE = 5'b10010;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACK      = 3'd1,
        ST_SAVE     = 3'd2,
        ST_VECTOR   = 3'd3,
        ST_RET_CPSR = 3'd4,
        ST_RET_PC   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] spsr_q, spsr_d;
    logic        in_irq_q, in_irq_d;

    logic ret_go;
    logic entry_go;

    // Return outranks entry so a handler that retires with a new IRQ pending unwinds first.
    assign ret_go   = instr_done & irq_ret & in_irq_q;
    assign entry_go = instr_done & INT_irq & ~cpsr_in[7];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            pc_q     <= 32'h0;
            spsr_q   <= 32'h0;
            in_irq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            spsr_q   <= spsr_d;
            in_irq_q <= in_irq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        spsr_d     = spsr_q;
        in_irq_d   = in_irq_q;
        INTA_irq   = 1'b0;
        PC_s       = 2'b00;
        Write_PC   = 1'b0;
        pc_wdata   = 32'h0;
        lr_we      = 1'b0;
        lr_wdata   = 32'h0;
        cpsr_we    = 1'b0;
        cpsr_wdata = 32'h0;
        stall      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                stall = 1'b0;
                if (ret_go) begin
                    state_d = ST_RET_CPSR;
                end else if (entry_go) begin
                    state_d = ST_ACK;
                    pc_d    = pc_in;
                    spsr_d  = cpsr_in;
                end
            end
            ST_ACK: begin
                INTA_irq = 1'b1;
                lr_we    = 1'b1;
                lr_wdata = pc_q + 32'd4;
                in_irq_d = 1'b1;
                state_d  = ST_SAVE;
            end
            ST_SAVE: begin
                cpsr_we    = 1'b1;
                cpsr_wdata = {spsr_q[31:8], 1'b1, spsr_q[6:5], IRQ_MODE};
                state_d    = ST_VECTOR;
            end
            ST_VECTOR: begin
                Write_PC = 1'b1;
                PC_s     = 2'b11;
                pc_wdata = VECTOR;
                state_d  = ST_IDLE;
            end
            ST_RET_CPSR: begin
                cpsr_we    = 1'b1;
                cpsr_wdata = spsr_q;
                state_d    = ST_RET_PC;
            end
            ST_RET_PC: begin
                Write_PC = 1'b1;
                PC_s     = 2'b11;
                pc_wdata = lr_in - 32'd4;
                in_irq_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                stall   = 1'b0;
            end
        endcase
    end

    assign in_irq = in_irq_q;

endmodule

// File: tb/tb_irq_entry_ctrl.sv
// tb/tb_irq_entry_ctrl.sv - directed self-checking bench for irq_entry_ctrl
module tb_irq_entry_ctrl;

    logic        clk;
    logic        clr;
    logic        INT_irq;
    logic        instr_done;
    logic        irq_ret;
    logic [31:0] cpsr_in;
    logic [31:0] pc_in;
    logic [31:0] lr_in;
    logic        INTA_irq;
    logic [1:0]  PC_s;
    logic        Write_PC;
    logic [31:0] pc_wdata;
    logic        lr_we;
    logic [31:0] lr_wdata;
    logic        cpsr_we;
    logic [31:0] cpsr_wdata;
    logic        stall;
    logic        in_irq;

    int checks;
    int errors;

    irq_entry_ctrl dut (
        .clk        (clk),
        .clr        (clr),
        .INT_irq    (INT_irq),
        .instr_done (instr_done),
        .irq_ret    (irq_ret),
        .cpsr_in    (cpsr_in),
        .pc_in      (pc_in),
        .lr_in      (lr_in),
        .INTA_irq   (INTA_irq),
        .PC_s       (PC_s),
        .Write_PC   (Write_PC),
        .pc_wdata   (pc_wdata),
        .lr_we      (lr_we),
        .lr_wdata   (lr_wdata),
        .cpsr_we    (cpsr_we),
        .cpsr_wdata (cpsr_wdata),
        .stall      (stall),
        .in_irq     (in_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle: {INTA_irq, lr_we, cpsr_we, Write_PC, PC_s, stall}
    function automatic logic [6:0] ctl();
        return {INTA_irq, lr_we, cpsr_we, Write_PC, PC_s, stall};
    endfunction

    task automatic idle_inputs();
        INT_irq    = 1'b0;
        instr_done = 1'b0;
        irq_ret    = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        idle_inputs();
        cpsr_in = 32'h0;
        pc_in   = 32'h0;
        lr_in   = 32'h0;
        @(negedge clk);
        checks++;
        if ({ctl(), in_irq, pc_wdata, lr_wdata, cpsr_wdata} !== 104'h0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b in_irq=%b pc=%h lr=%h cpsr=%h, want all 0",
                     ctl(), in_irq, pc_wdata, lr_wdata, cpsr_wdata);
        end
        clr = 1'b0;
        @(negedge clk);
    endtask

    // Triggers entry at the next edge and checks ACK, SAVE, VECTOR and the return to IDLE.
    task automatic run_entry(input string tag, input logic [31:0] pc, input logic [31:0] cpsr,
                             input logic [31:0] exp_lr, input logic [31:0] exp_cpsr);
        pc_in = pc; cpsr_in = cpsr; INT_irq = 1'b1; instr_done = 1'b1;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (ctl() !== 7'b1100001 || lr_wdata !== exp_lr) begin
            errors++;
            $display("FAIL %s_ack: ctl=%b lr_wdata=%h, want ctl=1100001 lr_wdata=%h", tag, ctl(), lr_wdata, exp_lr);
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0010001 || cpsr_wdata !== exp_cpsr || in_irq !== 1'b1) begin
            errors++;
            $display("FAIL %s_save: ctl=%b cpsr_wdata=%h in_irq=%b, want ctl=0010001 cpsr_wdata=%h in_irq=1",
                     tag, ctl(), cpsr_wdata, in_irq, exp_cpsr);
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0001111 || pc_wdata !== 32'h0000_0018) begin
            errors++;
            $display("FAIL %s_vector: ctl=%b pc_wdata=%h, want ctl=0001111 pc_wdata=00000018", tag, ctl(), pc_wdata);
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0000000 || in_irq !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: ctl=%b in_irq=%b, want ctl=0000000 in_irq=1", tag, ctl(), in_irq);
        end
    endtask

    task automatic run_return(input string tag, input logic [31:0] lr, input logic [31:0] exp_cpsr,
                              input logic [31:0] exp_pc, input logic also_irq);
        lr_in = lr; irq_ret = 1'b1; instr_done = 1'b1; INT_irq = also_irq; cpsr_in = 32'h0000_0010;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (ctl() !== 7'b0010001 || cpsr_wdata !== exp_cpsr) begin
            errors++;
            $display("FAIL %s_ret_cpsr: ctl=%b cpsr_wdata=%h, want ctl=0010001 cpsr_wdata=%h", tag, ctl(), cpsr_wdata, exp_cpsr);
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0001111 || pc_wdata !== exp_pc || in_irq !== 1'b1) begin
            errors++;
            $display("FAIL %s_ret_pc: ctl=%b pc_wdata=%h in_irq=%b, want ctl=0001111 pc_wdata=%h in_irq=1",
                     tag, ctl(), pc_wdata, in_irq, exp_pc);
        end
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0000000 || in_irq !== 1'b0) begin
            errors++;
            $display("FAIL %s_ret_idle: ctl=%b in_irq=%b, want ctl=0000000 in_irq=0", tag, ctl(), in_irq);
        end
    endtask

    task automatic test_entry();
        run_entry("entry", 32'h0000_0100, 32'h0000_0010, 32'h0000_0104, 32'h0000_0092);
    endtask

    task automatic test_return();
        run_return("return", 32'h0000_0108, 32'h0000_0010, 32'h0000_0104, 1'b0);
    endtask

    task automatic test_masked();
        cpsr_in = 32'h0000_0090; pc_in = 32'h0000_0200; INT_irq = 1'b1; instr_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl() !== 7'b0000000) begin
                errors++;
                $display("FAIL masked_%0d: ctl=%b, want 0000000", i, ctl());
            end
        end
        // Pending but no instruction boundary: still waits.
        cpsr_in = 32'h0000_0010; instr_done = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0000000) begin
            errors++;
            $display("FAIL no_instr_done: ctl=%b, want 0000000", ctl());
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous_spurious();
        run_entry("nest", 32'h0000_0300, 32'h0000_0010, 32'h0000_0304, 32'h0000_0092);
        run_return("simul", 32'h0000_0304, 32'h0000_0010, 32'h0000_0300, 1'b1);
        // Spurious return outside a handler produces nothing.
        irq_ret = 1'b1; instr_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl() !== 7'b0000000 || in_irq !== 1'b0) begin
                errors++;
                $display("FAIL spurious_%0d: ctl=%b in_irq=%b, want 0000000/0", i, ctl(), in_irq);
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        run_entry("wrap", 32'hFFFF_FFFC, 32'hA000_0013, 32'h0000_0000, 32'hA000_0092);
        run_return("wrap", 32'h0000_0000, 32'hA000_0013, 32'hFFFF_FFFC, 1'b0);
    endtask

    task automatic test_reset_mid_sequence();
        pc_in = 32'h0000_0400; cpsr_in = 32'h0000_0010; INT_irq = 1'b1; instr_done = 1'b1;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        checks++;
        if (cpsr_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_save: cpsr_we=%b, want 1", cpsr_we);
        end
        clr = 1'b1;
        #1;
        checks++;
        if ({ctl(), in_irq, pc_wdata, lr_wdata, cpsr_wdata} !== 104'h0) begin
            errors++;
            $display("FAIL mid_reset: ctl=%b in_irq=%b pc=%h lr=%h cpsr=%h, want all 0",
                     ctl(), in_irq, pc_wdata, lr_wdata, cpsr_wdata);
        end
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0000000) begin
            errors++;
            $display("FAIL after_reset_idle: ctl=%b, want 0000000", ctl());
        end
        run_entry("restart", 32'h0000_0500, 32'h0000_0010, 32'h0000_0504, 32'h0000_0092);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_entry();
        test_return();
        test_masked();
        test_simultaneous_spurious();
        test_wrap();
        test_reset_mid_sequence();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
